// File: rtl/sci_display_decoder.sv
// sci_display_decoder: captures the four 7-segment display buses, decodes the glyphs
// back to BCD, validates the mantissa/E/exponent format and streams the expanded
// decimal value MSD-first over a valid/ready digit interface.
module sci_display_decoder #(
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned MAX_EXP        = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample,
   input  logic [6:0] sev_seg0,
   input  logic [6:0] sev_seg1,
   input  logic [6:0] sev_seg2,
   input  logic [6:0] sev_seg3,
   output logic [3:0] digit_out,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic       digit_last,
   output logic [3:0] exp_out,
   output logic       busy,
   output logic       err
);

   localparam logic [3:0] GLYPH_E   = 4'hE;
   localparam logic [3:0] MAX_EXP_L = 4'(MAX_EXP);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DECODE  = 2'd2,
      EMIT    = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] raw0_q, raw1_q, raw2_q, raw3_q;
   // decoded glyphs: bit 4 = legal glyph, bits 3:0 = BCD value (E encoded as 4'hE)
   logic [4:0] msd_q, lsd_q, sep_q, exp_q;
   logic [3:0] cnt_q;
   logic [3:0] exp_q_out;
   logic       fmt_err;
   logic [3:0] total;

   // Map a glyph to {legal, value}; glyphs are normalised to active-low first.
   function automatic logic [4:0] glyph_to_bcd(input logic [6:0] g);
      logic [6:0] lo;
      lo = (SEG_ACTIVE_LOW != 0) ? g : ~g;
      case (lo)
         7'h40:   return {1'b1, 4'd0};
         7'h79:   return {1'b1, 4'd1};
         7'h24:   return {1'b1, 4'd2};
         7'h30:   return {1'b1, 4'd3};
         7'h19:   return {1'b1, 4'd4};
         7'h12:   return {1'b1, 4'd5};
         7'h02:   return {1'b1, 4'd6};
         7'h78:   return {1'b1, 4'd7};
         7'h00:   return {1'b1, 4'd8};
         7'h10:   return {1'b1, 4'd9};
         7'h06:   return {1'b1, GLYPH_E};
         default: return {1'b0, 4'd0};
      endcase
   endfunction

   // Format check on the decoded glyphs, consumed in DECODE.
   always_comb begin
      fmt_err = 1'b0;
      if (!(msd_q[4] && lsd_q[4] && sep_q[4] && exp_q[4])) fmt_err = 1'b1;
      if (sep_q[3:0] != GLYPH_E)                          fmt_err = 1'b1;
      if (msd_q[3:0] == GLYPH_E || lsd_q[3:0] == GLYPH_E) fmt_err = 1'b1;
      if (exp_q[3:0] == GLYPH_E || exp_q[3:0] > MAX_EXP_L) fmt_err = 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and outputs; the digit emitted is chosen by how far the remaining
   // count is below its starting value (exp + 2): msd first, lsd second, then zeros.
   always_comb begin
      state_d     = state_q;
      busy        = 1'b0;
      err         = 1'b0;
      digit_valid = 1'b0;
      digit_out   = '0;
      digit_last  = 1'b0;
      total       = exp_q_out + 4'd2;
      case (state_q)
         IDLE: begin
            if (sample) state_d = CAPTURE;
         end
         CAPTURE: begin
            busy    = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            busy = 1'b1;
            if (fmt_err) begin
               err     = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            busy        = 1'b1;
            digit_valid = 1'b1;
            digit_last  = (cnt_q == 4'd1);
            if (cnt_q == total)              digit_out = msd_q[3:0];
            else if (cnt_q == total - 4'd1)  digit_out = lsd_q[3:0];
            else                             digit_out = '0;
            if (digit_ready && cnt_q == 4'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: bus capture, glyph decode, count load and per-handshake count-down.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         raw0_q    <= '0;
         raw1_q    <= '0;
         raw2_q    <= '0;
         raw3_q    <= '0;
         msd_q     <= '0;
         lsd_q     <= '0;
         sep_q     <= '0;
         exp_q     <= '0;
         cnt_q     <= '0;
         exp_q_out <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sample) begin
                  raw0_q <= sev_seg0;
                  raw1_q <= sev_seg1;
                  raw2_q <= sev_seg2;
                  raw3_q <= sev_seg3;
               end
            end
            CAPTURE: begin
               msd_q <= glyph_to_bcd(raw0_q);
               lsd_q <= glyph_to_bcd(raw1_q);
               sep_q <= glyph_to_bcd(raw2_q);
               exp_q <= glyph_to_bcd(raw3_q);
            end
            DECODE: begin
               if (!fmt_err) begin
                  cnt_q     <= exp_q[3:0] + 4'd2;
                  exp_q_out <= exp_q[3:0];
               end
            end
            EMIT: begin
               if (digit_ready) cnt_q <= cnt_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign exp_out = exp_q_out;

endmodule

// File: tb/tb_sci_display_decoder.sv
// tb_sci_display_decoder: directed scenarios for the display decoder with
// hand-computed digit streams.
module tb_sci_display_decoder;

   logic       clk;
   logic       rst;
   logic       sample;
   logic [6:0] sev_seg0, sev_seg1, sev_seg2, sev_seg3;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic       digit_ready;
   logic       digit_last;
   logic [3:0] exp_out;
   logic       busy;
   logic       err;

   int checks   = 0;
   int failures = 0;

   // collector results
   logic [3:0] got_d [16];
   logic       got_l [16];
   int         got_n;
   int         first_acc;
   int         last_acc;
   int         hold_bad;
   int         err_cnt;
   int         err_cyc;
   int         valid_seen;
   int         exp_seen;
   logic       done;

   localparam logic [6:0] G_E     = 7'h06;
   localparam logic [6:0] G_BLANK = 7'h7F;

   sci_display_decoder #(.SEG_ACTIVE_LOW(1), .MAX_EXP(9)) dut (
      .clk(clk), .rst(rst), .sample(sample),
      .sev_seg0(sev_seg0), .sev_seg1(sev_seg1), .sev_seg2(sev_seg2), .sev_seg3(sev_seg3),
      .digit_out(digit_out), .digit_valid(digit_valid), .digit_ready(digit_ready),
      .digit_last(digit_last), .exp_out(exp_out), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] gl(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Drive the buses and pulse sample for one cycle; returns at the negedge after capture.
   task automatic kick(input logic [6:0] s0, s1, s2, s3);
      @(negedge clk);
      sev_seg0 = s0; sev_seg1 = s1; sev_seg2 = s2; sev_seg3 = s3;
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
   endtask

   // Observe the stream at each negedge (cycle 0 = CAPTURE state) until the last digit
   // is accepted or maxc cycles pass; optionally toggles ready and injects a sample pulse.
   task automatic collect(input int maxc, input bit toggle, input int inj_cyc,
                          input logic [6:0] i0, i1, i2, i3);
      logic [3:0] hd;
      logic       hl;
      bit         have_hold;
      have_hold = 0; got_n = 0; first_acc = -1; last_acc = -1; hold_bad = 0;
      err_cnt = 0; err_cyc = -1; valid_seen = 0; exp_seen = -1; done = 0;
      hd = '0; hl = 1'b0;
      for (int c = 0; c < maxc && !done; c++) begin
         digit_ready = toggle ? (c % 2 == 0) : 1'b1;
         if (c == inj_cyc) begin
            sev_seg0 = i0; sev_seg1 = i1; sev_seg2 = i2; sev_seg3 = i3;
            sample = 1'b1;
         end else begin
            sample = 1'b0;
         end
         if (err) begin err_cnt++; err_cyc = c; end
         if (digit_valid) begin
            valid_seen++;
            exp_seen = int'(exp_out);
            if (have_hold && (digit_out !== hd || digit_last !== hl)) hold_bad++;
            if (digit_ready) begin
               if (first_acc < 0) first_acc = c;
               last_acc = c;
               if (got_n < 16) begin
                  got_d[got_n] = digit_out;
                  got_l[got_n] = digit_last;
               end
               got_n++;
               have_hold = 0;
               if (digit_last) done = 1;
            end else begin
               hd = digit_out; hl = digit_last; have_hold = 1;
            end
         end
         @(negedge clk);
      end
      sample = 1'b0;
      digit_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({digit_out, digit_valid, digit_last, exp_out, busy, err} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=0", {digit_out, digit_valid, digit_last, exp_out, busy, err});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", busy); end
   endtask

   task automatic test_basic;
      kick(gl(3), gl(7), G_E, gl(0));
      checks++;
      if (busy !== 1'b1 || digit_valid !== 1'b0) begin
         failures++; $display("FAIL basic_capture busy=%b valid=%b want 1,0", busy, digit_valid);
      end
      collect(20, 0, -1, '0, '0, '0, '0);
      checks++;
      if (!done || got_n != 2) begin failures++; $display("FAIL basic_count got=%0d done=%0d want 2", got_n, done); end
      else begin
         checks++;
         if (got_d[0] !== 4'd3 || got_d[1] !== 4'd7) begin
            failures++; $display("FAIL basic_digits got=%0d,%0d want 3,7", got_d[0], got_d[1]);
         end
         checks++;
         if (got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin
            failures++; $display("FAIL basic_last got=%b%b want 01", got_l[0], got_l[1]);
         end
      end
      checks++;
      if (first_acc != 2) begin failures++; $display("FAIL basic_latency got=%0d want 2", first_acc); end
      checks++;
      if (exp_seen != 0 || err_cnt != 0) begin
         failures++; $display("FAIL basic_exp_err exp=%0d err=%0d want 0,0", exp_seen, err_cnt);
      end
   endtask

   task automatic test_exp3;
      logic [3:0] want [5];
      want = '{4'd4, 4'd2, 4'd0, 4'd0, 4'd0};
      kick(gl(4), gl(2), G_E, gl(3));
      collect(20, 0, -1, '0, '0, '0, '0);
      checks++;
      if (!done || got_n != 5) begin failures++; $display("FAIL exp3_count got=%0d want 5", got_n); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_d[i] !== want[i] || got_l[i] !== (i == 4)) begin
               failures++; $display("FAIL exp3_digit%0d got=%0d/%b want %0d/%b", i, got_d[i], got_l[i], want[i], i == 4);
            end
         end
      end
      checks++;
      if (last_acc - first_acc != 4) begin failures++; $display("FAIL exp3_throughput span=%0d want 4", last_acc - first_acc); end
      checks++;
      if (busy !== 1'b0 || digit_valid !== 1'b0) begin
         failures++; $display("FAIL exp3_done busy=%b valid=%b want 0,0", busy, digit_valid);
      end
   endtask

   task automatic test_backpressure;
      int bad;
      kick(gl(9), gl(9), G_E, gl(9));
      collect(40, 1, -1, '0, '0, '0, '0);
      checks++;
      if (!done || got_n != 11) begin failures++; $display("FAIL bp_count got=%0d want 11", got_n); end
      else begin
         bad = 0;
         for (int i = 0; i < 11; i++)
            if (got_d[i] !== ((i < 2) ? 4'd9 : 4'd0) || got_l[i] !== (i == 10)) bad++;
         checks++;
         if (bad != 0) begin failures++; $display("FAIL bp_digits bad=%0d want 0", bad); end
      end
      checks++;
      if (hold_bad != 0) begin failures++; $display("FAIL bp_hold unstable=%0d want 0", hold_bad); end
      checks++;
      if (exp_seen != 9) begin failures++; $display("FAIL bp_exp got=%0d want 9", exp_seen); end
   endtask

   task automatic test_format_err;
      logic [6:0] s0 [4];
      logic [6:0] s2 [4];
      logic [6:0] s3 [4];
      s0 = '{gl(3), G_BLANK, G_E,  gl(3)};
      s2 = '{gl(3), G_E,     G_E,  G_E};
      s3 = '{gl(0), gl(0),   gl(1), G_E};
      for (int k = 0; k < 4; k++) begin
         kick(s0[k], gl(7), s2[k], s3[k]);
         collect(8, 0, -1, '0, '0, '0, '0);
         checks++;
         if (err_cnt != 1 || err_cyc != 1) begin
            failures++; $display("FAIL err%0d_pulse cnt=%0d cyc=%0d want 1,1", k, err_cnt, err_cyc);
         end
         checks++;
         if (valid_seen != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL err%0d_novalid valid=%0d busy=%b want 0,0", k, valid_seen, busy);
         end
      end
   endtask

   task automatic test_ignore_sample;
      kick(gl(4), gl(2), G_E, gl(3));
      collect(20, 0, 3, gl(1), gl(5), G_E, gl(1));
      checks++;
      if (!done || got_n != 5 || got_d[0] !== 4'd4 || got_d[1] !== 4'd2 || got_d[2] !== 4'd0) begin
         failures++; $display("FAIL ignore_stream n=%0d d0=%0d d1=%0d want 5,4,2", got_n, got_d[0], got_d[1]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle busy=%b want 0", busy); end
      kick(gl(1), gl(5), G_E, gl(1));
      collect(20, 0, -1, '0, '0, '0, '0);
      checks++;
      if (got_n != 3 || got_d[0] !== 4'd1 || got_d[1] !== 4'd5 || got_d[2] !== 4'd0 || got_l[2] !== 1'b1) begin
         failures++; $display("FAIL ignore_new n=%0d d=%0d%0d%0d want 3 digits 150", got_n, got_d[0], got_d[1], got_d[2]);
      end
   endtask

   task automatic test_reset_mid_emit;
      kick(gl(4), gl(2), G_E, gl(3));
      digit_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (digit_valid !== 1'b1 || exp_out !== 4'd3) begin
         failures++; $display("FAIL rstmid_pre valid=%b exp=%0d want 1,3", digit_valid, exp_out);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (digit_valid !== 1'b0 || busy !== 1'b0 || digit_last !== 1'b0 || exp_out !== 4'd0) begin
         failures++; $display("FAIL rstmid_async valid=%b busy=%b last=%b exp=%0d want 0", digit_valid, busy, digit_last, exp_out);
      end
      @(negedge clk);
      rst = 1'b1;
      digit_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || digit_valid !== 1'b0) begin
         failures++; $display("FAIL rstmid_idle busy=%b valid=%b want 0,0", busy, digit_valid);
      end
      kick(gl(0), gl(7), G_E, gl(0));
      collect(20, 0, -1, '0, '0, '0, '0);
      checks++;
      if (got_n != 2 || got_d[0] !== 4'd0 || got_d[1] !== 4'd7 || got_l[1] !== 1'b1) begin
         failures++; $display("FAIL rstmid_after n=%0d d=%0d%0d want 2 digits 07", got_n, got_d[0], got_d[1]);
      end
   endtask

   initial begin
      sample = 1'b0; digit_ready = 1'b1;
      sev_seg0 = 7'h7F; sev_seg1 = 7'h7F; sev_seg2 = 7'h7F; sev_seg3 = 7'h7F;
      rst = 1'b0;
      test_reset;
      test_basic;
      test_exp3;
      test_backpressure;
      test_format_err;
      test_ignore_sample;
      test_reset_mid_emit;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
